// File: rtl/interval_timer_slave_if.sv
// Avalon-MM register-bus bundle between the Nios II master and the interval timer.
//   address    : word address of the register
//   chipselect : slave selected, qualifies read/write
//   write/read : access strobes
//   writedata  : write data
//   readdata   : registered read data, latency 1
interface interval_timer_slave_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output address, chipselect, write, read, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write, read, writedata,
        output readdata
    );
endinterface

// File: rtl/interval_timer_slave.sv
// Avalon-MM interval timer: 32-bit down-counter with reload period, control/status
// and snapshot registers in a 16-bit, 8-word register window; level interrupt on timeout.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : Avalon-MM slave port (address, chipselect, write, read, writedata, readdata)
//   irq     : level interrupt, TO & ITO
module interval_timer_slave #(
    parameter logic [31:0] DEFAULT_PERIOD = 32'd49_999
) (
    input  logic                   clk,
    input  logic                   reset_n,
    interval_timer_slave_if.slave  bus,
    output logic                   irq
);
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_STATUS  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_CONTROL = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_PERIODL = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_PERIODH = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] ADDR_SNAPL   = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ADDR_SNAPH   = ADDR_W'(5);

    logic [CNT_W-1:0]  counter,  counter_nxt;
    logic [CNT_W-1:0]  period,   period_nxt;
    logic [CNT_W-1:0]  snapshot, snapshot_nxt;
    logic              to_flag,  to_nxt;
    logic              run,      run_nxt;
    logic              ito,      ito_nxt;
    logic              cont,     cont_nxt;
    logic [DATA_W-1:0] readdata, readdata_nxt;

    logic              wr_c;
    logic              rd_c;
    logic              timeout_c;
    logic [DATA_W-1:0] read_mux_c;

    assign wr_c      = bus.chipselect & bus.write;
    assign rd_c      = bus.chipselect & bus.read;
    assign timeout_c = run & (counter == '0);

    // Read mux; always sees pre-edge register values.
    always_comb begin
        read_mux_c = '0;
        case (bus.address)
            ADDR_STATUS:  read_mux_c = DATA_W'({run, to_flag});
            ADDR_CONTROL: read_mux_c = DATA_W'({cont, ito});
            ADDR_PERIODL: read_mux_c = period[DATA_W-1:0];
            ADDR_PERIODH: read_mux_c = period[CNT_W-1:DATA_W];
            ADDR_SNAPL:   read_mux_c = snapshot[DATA_W-1:0];
            ADDR_SNAPH:   read_mux_c = snapshot[CNT_W-1:DATA_W];
            default:      read_mux_c = '0;
        endcase
    end

    // Next-state: counting first, then bus writes override where they collide.
    always_comb begin
        counter_nxt  = counter;
        period_nxt   = period;
        snapshot_nxt = snapshot;
        to_nxt       = to_flag;
        run_nxt      = run;
        ito_nxt      = ito;
        cont_nxt     = cont;
        readdata_nxt = readdata;

        if (rd_c) begin
            readdata_nxt = read_mux_c;
        end

        if (run) begin
            if (timeout_c) begin
                counter_nxt = period;
                to_nxt      = 1'b1;
                run_nxt     = cont;
            end else begin
                counter_nxt = counter - CNT_W'(1);
            end
        end

        if (wr_c) begin
            case (bus.address)
                ADDR_STATUS: begin
                    // A timeout on the same edge keeps TO set.
                    if (!timeout_c) begin
                        to_nxt = 1'b0;
                    end
                end
                ADDR_CONTROL: begin
                    ito_nxt  = bus.writedata[0];
                    cont_nxt = bus.writedata[1];
                    if (bus.writedata[3]) begin
                        run_nxt = 1'b0;
                    end else if (bus.writedata[2]) begin
                        run_nxt = 1'b1;
                    end
                end
                ADDR_PERIODL: begin
                    period_nxt[DATA_W-1:0] = bus.writedata;
                    counter_nxt            = period_nxt;
                    run_nxt                = 1'b0;
                end
                ADDR_PERIODH: begin
                    period_nxt[CNT_W-1:DATA_W] = bus.writedata;
                    counter_nxt                = period_nxt;
                    run_nxt                    = 1'b0;
                end
                ADDR_SNAPL, ADDR_SNAPH: begin
                    // Captures the pre-edge counter value.
                    snapshot_nxt = counter;
                end
                default: ;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter  <= DEFAULT_PERIOD;
            period   <= DEFAULT_PERIOD;
            snapshot <= '0;
            to_flag  <= 1'b0;
            run      <= 1'b0;
            ito      <= 1'b0;
            cont     <= 1'b0;
            readdata <= '0;
        end else begin
            counter  <= counter_nxt;
            period   <= period_nxt;
            snapshot <= snapshot_nxt;
            to_flag  <= to_nxt;
            run      <= run_nxt;
            ito      <= ito_nxt;
            cont     <= cont_nxt;
            readdata <= readdata_nxt;
        end
    end

    assign bus.readdata = readdata;
    assign irq          = to_flag & ito;

endmodule

// File: tb/tb_interval_timer_slave.sv
// Self-checking bench for interval_timer_slave: directed scenarios with arithmetic
// expectations plus a randomized run against a register-level reference model.
module tb_interval_timer_slave;
    localparam logic [31:0] DEF_PERIOD = 32'd49_999;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic irq;

    interval_timer_slave_if bus();

    interval_timer_slave #(.DEFAULT_PERIOD(DEF_PERIOD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_cnt, m_per, m_snap;
    bit          m_to, m_run, m_ito, m_cont;
    logic [15:0] m_rd;

    task automatic model_reset();
        m_cnt = DEF_PERIOD; m_per = DEF_PERIOD; m_snap = '0;
        m_to = 0; m_run = 0; m_ito = 0; m_cont = 0; m_rd = '0;
    endtask

    function automatic logic [15:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return {14'd0, m_run, m_to};
            3'd1: return {14'd0, m_cont, m_ito};
            3'd2: return m_per[15:0];
            3'd3: return m_per[31:16];
            3'd4: return m_snap[15:0];
            3'd5: return m_snap[31:16];
            default: return 16'd0;
        endcase
    endfunction

    // One clock edge of the register-level behaviour.
    task automatic model_edge(input bit cs, input bit we, input bit re,
                              input logic [2:0] a, input logic [15:0] d);
        logic [31:0] cnt, per, snap;
        bit to, run, ito, cont, fired;
        cnt = m_cnt; per = m_per; snap = m_snap;
        to = m_to; run = m_run; ito = m_ito; cont = m_cont;
        fired = m_run && (m_cnt == 0);
        if (cs && re) m_rd = model_read(a);
        if (fired) begin
            cnt = m_per; to = 1; run = m_cont;
        end else if (m_run) begin
            cnt = m_cnt - 1;
        end
        if (cs && we) begin
            if (a == 3'd0 && !fired) to = 0;
            if (a == 3'd1) begin
                ito = d[0]; cont = d[1];
                if (d[3]) run = 0;
                else if (d[2]) run = 1;
            end
            if (a == 3'd2 || a == 3'd3) begin
                if (a == 3'd2) per = {m_per[31:16], d};
                else           per = {d, m_per[15:0]};
                cnt = per; run = 0;
            end
            if (a == 3'd4 || a == 3'd5) snap = m_cnt;
        end
        m_cnt = cnt; m_per = per; m_snap = snap;
        m_to = to; m_run = run; m_ito = ito; m_cont = cont;
    endtask

    // Drive one bus cycle from a negedge, advance the model at the posedge,
    // return at the following negedge (a safe sampling point).
    task automatic cycle(input bit cs, input bit we, input bit re,
                         input logic [2:0] a, input logic [15:0] d);
        bus.chipselect = cs; bus.write = we; bus.read = re;
        bus.address = a; bus.writedata = d;
        @(posedge clk);
        model_edge(cs, we, re, a, d);
        @(negedge clk);
        bus.chipselect = 0; bus.write = 0; bus.read = 0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        cycle(1, 1, 0, a, d);
    endtask

    task automatic rd(input logic [2:0] a);
        cycle(1, 0, 1, a, 16'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 3'd0, 16'd0);
    endtask

    task automatic test_reset();
        logic [15:0] exp_rd [4];
        logic [2:0]  addr   [4];
        reset_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.readdata !== 16'd0) begin
            n_err++; $display("FAIL reset_readdata got %h exp 0000", bus.readdata);
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++; $display("FAIL reset_irq got %b exp 0", irq);
        end
        reset_n = 1;
        addr[0] = 3'd2; exp_rd[0] = 16'hC34F;
        addr[1] = 3'd3; exp_rd[1] = 16'h0000;
        addr[2] = 3'd0; exp_rd[2] = 16'h0000;
        addr[3] = 3'd1; exp_rd[3] = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            rd(addr[i]);
            n_cmp++;
            if (bus.readdata !== exp_rd[i]) begin
                n_err++;
                $display("FAIL reset_read addr %0d got %h exp %h", addr[i], bus.readdata, exp_rd[i]);
            end
        end
    endtask

    task automatic test_periodic();
        bit exp_irq;
        wr(3'd2, 16'd4); wr(3'd3, 16'd0); wr(3'd1, 16'h3); wr(3'd1, 16'h7);
        // k counts edges after the START edge; period 4 -> timeouts at k=5 and k=10.
        for (int k = 1; k <= 10; k++) begin
            if (k == 6) wr(3'd0, 16'd0);
            else        idle(1);
            exp_irq = (k == 5) || (k >= 10);
            n_cmp++;
            if (irq !== exp_irq) begin
                n_err++; $display("FAIL periodic_irq k=%0d got %b exp %b", k, irq, exp_irq);
            end
        end
        rd(3'd0);
        n_cmp++;
        if (bus.readdata !== 16'h0003) begin
            n_err++; $display("FAIL periodic_status got %h exp 0003", bus.readdata);
        end
        wr(3'd1, 16'h8); wr(3'd0, 16'd0);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++; $display("FAIL periodic_stop_irq got %b exp 0", irq);
        end
    endtask

    task automatic test_oneshot();
        bit exp_irq;
        wr(3'd2, 16'd2); wr(3'd3, 16'd0); wr(3'd0, 16'd0); wr(3'd1, 16'h5);
        for (int k = 1; k <= 4; k++) begin
            idle(1);
            exp_irq = (k >= 3);
            n_cmp++;
            if (irq !== exp_irq) begin
                n_err++; $display("FAIL oneshot_irq k=%0d got %b exp %b", k, irq, exp_irq);
            end
        end
        rd(3'd0);
        n_cmp++;
        if (bus.readdata !== 16'h0001) begin
            n_err++; $display("FAIL oneshot_status got %h exp 0001", bus.readdata);
        end
        idle(5);
        wr(3'd4, 16'd0); rd(3'd4);
        n_cmp++;
        if (bus.readdata !== 16'd2) begin
            n_err++; $display("FAIL oneshot_hold got %h exp 0002", bus.readdata);
        end
        wr(3'd0, 16'd0); wr(3'd1, 16'd0);
    endtask

    task automatic test_midcount();
        wr(3'd2, 16'd100); wr(3'd3, 16'd0); wr(3'd1, 16'h4);
        idle(10);
        wr(3'd4, 16'd0);         // edge S+11 captures 100-10
        rd(3'd4);
        n_cmp++;
        if (bus.readdata !== 16'd90) begin
            n_err++; $display("FAIL midcount_snapl got %0d exp 90", bus.readdata);
        end
        rd(3'd5);
        n_cmp++;
        if (bus.readdata !== 16'd0) begin
            n_err++; $display("FAIL midcount_snaph got %0d exp 0", bus.readdata);
        end
        wr(3'd1, 16'h8);         // STOP at edge S+14 -> frozen at 86
        idle(5);
        wr(3'd5, 16'd0); rd(3'd4);
        n_cmp++;
        if (bus.readdata !== 16'd86) begin
            n_err++; $display("FAIL midcount_frozen got %0d exp 86", bus.readdata);
        end
        rd(3'd0);
        n_cmp++;
        if (bus.readdata !== 16'd0) begin
            n_err++; $display("FAIL midcount_stopped got %h exp 0000", bus.readdata);
        end
        wr(3'd1, 16'hC);         // START+STOP: stays stopped
        idle(3);
        wr(3'd4, 16'd0); rd(3'd4);
        n_cmp++;
        if (bus.readdata !== 16'd86) begin
            n_err++; $display("FAIL midcount_startstop got %0d exp 86", bus.readdata);
        end
    endtask

    task automatic test_period_write_running();
        wr(3'd2, 16'd100); wr(3'd3, 16'd0); wr(3'd1, 16'h4);
        idle(5);
        wr(3'd2, 16'd7);
        rd(3'd0);
        n_cmp++;
        if (bus.readdata !== 16'd0) begin
            n_err++; $display("FAIL pwrite_run got %h exp 0000", bus.readdata);
        end
        wr(3'd4, 16'd0); rd(3'd4);
        n_cmp++;
        if (bus.readdata !== 16'd7) begin
            n_err++; $display("FAIL pwrite_reload got %0d exp 7", bus.readdata);
        end
        wr(3'd1, 16'h7);         // START at S, timeout at S+8
        idle(7);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++; $display("FAIL clr_race_pre got %b exp 0", irq);
        end
        wr(3'd0, 16'd0);         // clear on the timeout edge
        n_cmp++;
        if (irq !== 1'b1) begin
            n_err++; $display("FAIL clr_race_irq got %b exp 1", irq);
        end
        rd(3'd0);
        n_cmp++;
        if (bus.readdata !== 16'h0003) begin
            n_err++; $display("FAIL clr_race_status got %h exp 0003", bus.readdata);
        end
        wr(3'd1, 16'h8); wr(3'd0, 16'd0);
    endtask

    task automatic test_period_zero();
        wr(3'd2, 16'd0); wr(3'd3, 16'd0); wr(3'd1, 16'h7);
        for (int k = 1; k <= 4; k++) begin
            wr(3'd0, 16'd0);     // every edge times out, so TO never clears
            n_cmp++;
            if (irq !== 1'b1) begin
                n_err++; $display("FAIL period0_irq k=%0d got %b exp 1", k, irq);
            end
        end
        wr(3'd1, 16'h8); wr(3'd0, 16'd0);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++; $display("FAIL period0_stop got %b exp 0", irq);
        end
    endtask

    task automatic test_random();
        int op;
        logic [2:0] a;
        wr(3'd3, 16'd0);
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 9);
            a  = 3'($urandom_range(0, 7));
            case (op)
                0, 1, 2: rd(a);
                3: wr(3'd0, 16'($urandom));
                4: wr(3'd1, 16'($urandom_range(0, 15)));
                5: wr(3'd2, 16'($urandom_range(0, 6)));
                6: wr(3'd3, ($urandom_range(0, 15) == 0) ? 16'($urandom_range(0, 3)) : 16'd0);
                7: wr(3'($urandom_range(4, 5)), 16'($urandom));
                8: begin
                    if ($urandom_range(0, 1) == 1) wr(3'($urandom_range(6, 7)), 16'($urandom));
                    else cycle(0, 1, 1'($urandom_range(0, 1)), a, 16'($urandom));
                end
                default: idle(1);
            endcase
            n_cmp++;
            if (bus.readdata !== m_rd) begin
                n_err++; $display("FAIL random_readdata i=%0d got %h exp %h", i, bus.readdata, m_rd);
            end
            n_cmp++;
            if (irq !== (m_to & m_ito)) begin
                n_err++; $display("FAIL random_irq i=%0d got %b exp %b", i, irq, m_to & m_ito);
            end
        end
        wr(3'd1, 16'h8); wr(3'd0, 16'd0);
    endtask

    task automatic test_async_reset();
        wr(3'd2, 16'd3); wr(3'd3, 16'd0); wr(3'd0, 16'd0); wr(3'd1, 16'h7);
        idle(5);
        rd(3'd2);
        n_cmp++;
        if (irq !== 1'b1 || bus.readdata !== 16'd3) begin
            n_err++; $display("FAIL areset_pre irq %b rd %h exp 1 0003", irq, bus.readdata);
        end
        #2 reset_n = 0;
        #1;
        n_cmp++;
        if (irq !== 1'b0 || bus.readdata !== 16'd0) begin
            n_err++; $display("FAIL areset_now irq %b rd %h exp 0 0000", irq, bus.readdata);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;
        idle(20);
        rd(3'd0);
        n_cmp++;
        if (bus.readdata !== 16'd0) begin
            n_err++; $display("FAIL areset_status got %h exp 0000", bus.readdata);
        end
        wr(3'd4, 16'd0); rd(3'd4);
        n_cmp++;
        if (bus.readdata !== 16'hC34F) begin
            n_err++; $display("FAIL areset_nocount got %h exp c34f", bus.readdata);
        end
        rd(3'd2);
        n_cmp++;
        if (bus.readdata !== 16'hC34F) begin
            n_err++; $display("FAIL areset_period got %h exp c34f", bus.readdata);
        end
    endtask

    initial begin
        bus.chipselect = 0; bus.write = 0; bus.read = 0;
        bus.address = '0; bus.writedata = '0;
        model_reset();
        test_reset();
        test_periodic();
        test_oneshot();
        test_midcount();
        test_period_write_running();
        test_period_zero();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/interval_timer_slave.md
# interval_timer_slave

Avalon-MM slave interval timer: the responder on the same Avalon-MM bus that the Nios II system in the board top level drives as bus master. It holds a 32-bit down-counter, reload period, control/status and snapshot registers behind a 16-bit register window. It raises a level interrupt on timeout and instantiates as a custom component alongside the key, LED and HEX PIOs.

## Interface
- DEFAULT_PERIOD, 32'd49_999, counter/period reset value; timeout interval is (period+1) clk cycles, 1 ms at 50 MHz by default
- clk  input  1  system clock (50 MHz domain)
- reset_n  input  1  asynchronous, active-low reset
- address  input  3  word address of register
- chipselect  input  1  slave selected
- write  input  1  write strobe, qualified by chipselect
- read  input  1  read strobe, qualified by chipselect
- writedata  input  16  write data
- readdata  output  16  read data, registered, read latency 1
- irq  output  1  level interrupt, equals TO & ITO

## Operation
- Register map (word addresses):
  - 0 STATUS: bit0 TO, write any value clears; bit1 RUN, read-only.
  - 1 CONTROL: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP. START and STOP are write-only strobes and read back 0.
  - 2 PERIODL, 3 PERIODH: read/write halves of the period register.
  - 4 SNAPL, 5 SNAPH: any write to 4 or 5 copies the live counter into the snapshot; reads return the snapshot halves.
  - 6–7: reads return 0; writes are ignored.
- Unused readdata bits are 0.
- Counter behaviour while RUN=1: decrements by 1 each cycle.
  - On a cycle with counter==0: next edge counter<=period, TO<=1, RUN<=CONT.
- While RUN=0 the counter holds its value.
- START write: RUN<=1, and counting continues from the current counter value.
  - STOP write: RUN<=0.
  - START and STOP in the same write: STOP wins.
- PERIODL/PERIODH write: updates that half, reloads the counter with the new full period and forces RUN<=0.
- Priority: a timeout in the same cycle as a STATUS clear leaves TO=1, because set wins.
- A snapshot write in the same cycle as decrement or reload captures the pre-edge counter value.
- Period 0 with CONT=1 and RUN=1 gives a timeout every cycle.
- Reset (async, any time, including mid-count):
  - counter=period=DEFAULT_PERIOD
  - TO=RUN=ITO=CONT=0
  - snapshot=0, readdata=0, irq=0
- Counting resumes only on an explicit START after reset.

## Timing
- A write takes effect at the clk edge where chipselect&write are sampled high. A read of the same register in the next cycle sees the new value.
- Read: chipselect&read sampled at edge N; readdata is valid after edge N and is held until the next read.
- No waitrequest: every access completes in a single cycle.
- START sampled at edge S → counter decrements at edges S+1 … → TO=1 after edge S+period+1.
  - irq follows TO combinationally from registered TO and ITO, so it is asserted in the same cycle.
- irq deasserts after the edge that samples a STATUS write (unless a simultaneous timeout occurs) or one that clears ITO.
- One-shot mode (CONT=0): RUN=0 after the edge that reloads and sets TO.

## Test plan
- Reset with no writes → readdata=0, irq=0; reads return PERIODL=0xC34F, PERIODH=0x0000, STATUS=0, CONTROL=0.
- Write PERIODL=4, PERIODH=0, CONTROL=0x3 (ITO|CONT), then CONTROL=0x7 (START) → TO/irq high exactly 5 cycles after START. Clear STATUS → irq low, and TO rises again 5 cycles after the previous timeout.
- One-shot: PERIOD=2, CONTROL=0x5 → single timeout after 3 cycles; STATUS reads 0x0001 (RUN=0) and the counter holds at 2.
- Mid-count: PERIOD=100, START, wait 10 cycles, write SNAPL → SNAPL/SNAPH read the counter value at the write edge (≈90). Write CONTROL=0x8 → RUN=0 and the counter frozen; CONTROL=0xC → remains stopped.
- Period write while running: PERIOD=100 running, write PERIODL=7 → RUN=0 and the counter reloaded to 7; a STATUS write on the same cycle as a timeout leaves TO=1.
- Assert reset_n low asynchronously mid-count with irq high → irq, readdata and RUN go to 0 immediately; after release the period equals DEFAULT_PERIOD and no counting occurs.
